hazard_scoreboard_unit: RTL and testbench

- Parametrised successor to the pipeline's combinational forwarding/hazard logic.
- Keeps its own shadow of the EX/MEM/WB destination records, advanced each clock.
- Adds a per-register busy scoreboard for a fixed-latency multi-cycle multiply/divide unit (MDU).
- Sits beside the ID stage and produces four things: PC/IF-ID enables, the ID bubble, EX-stage operand forwarding selects and ID-stage branch forwarding selects.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 22 ++
 rtl/hazard_scoreboard_unit_mdu_scoreboard.sv | 66 ++++++
 rtl/hazard_scoreboard_unit.sv | 164 ++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the hazard/forwarding scoreboard.
// Forward-select encodings, default widths and the stage record type.
package hazard_scoreboard_unit_pkg;

   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_RD_PORTS   = 2;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   // Destination/source shadow of one pipeline stage
   typedef struct packed {
      logic                                   valid;
      logic                                   wr;
      logic                                   load;
      logic [DEF_REG_ADDR_W-1:0]              dest;
      logic [DEF_RD_PORTS*DEF_REG_ADDR_W-1:0] src;
      logic [DEF_RD_PORTS-1:0]                src_used;
   } stage_rec_t;

endpackage

// File: rtl/hazard_scoreboard_unit_mdu_scoreboard.sv
// Busy scoreboard and countdown for the fixed-latency multiply/divide unit.
// A writeback clear and a same-edge re-issue to one register leave it busy.
module mdu_scoreboard
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int NUM_REGS     = 2**REG_ADDR_W,
   parameter int NUM_RD_PORTS = DEF_RD_PORTS,
   parameter int MDU_LATENCY  = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               issue,
   input  logic                               issue_wr,
   input  logic [REG_ADDR_W-1:0]              issue_dest,
   input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] src,
   input  logic [NUM_RD_PORTS-1:0]            src_used,
   input  logic [REG_ADDR_W-1:0]              dest,
   input  logic                               reg_write,
   output logic                               raw,
   output logic                               waw,
   output logic                               active,
   output logic                               wb_valid,
   output logic [REG_ADDR_W-1:0]              wb_dest
);

   localparam logic [3:0] LAT = 4'(MDU_LATENCY);

   logic [NUM_REGS-1:0]   busy;
   logic [3:0]            cnt;
   logic [REG_ADDR_W-1:0] mdu_dest;

   // Countdown, in-flight destination and busy bits; issue wins over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         cnt      <= '0;
         mdu_dest <= '0;
      end else begin
         if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if (cnt == 4'd1)
            busy[mdu_dest] <= 1'b0;
         if (issue) begin
            cnt      <= LAT;
            mdu_dest <= issue_dest;
            if (issue_wr && issue_dest != '0)
               busy[issue_dest] <= 1'b1;
         end
      end
   end

   // Read-after-write check against every used source
   always_comb begin
      raw = 1'b0;
      for (int p = 0; p < NUM_RD_PORTS; p++)
         if (src_used[p] && busy[src[p*REG_ADDR_W +: REG_ADDR_W]])
            raw = 1'b1;
   end

   assign waw      = reg_write & busy[dest];
   assign active   = (cnt != 4'd0);
   assign wb_valid = (cnt == 4'd1);
   assign wb_dest  = mdu_dest;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Stall, bubble and forwarding control beside the ID stage, with MDU scoreboard.
// Optional stall counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int NUM_REGS     = 2**REG_ADDR_W,
   parameter int NUM_RD_PORTS = DEF_RD_PORTS,
   parameter int MDU_LATENCY  = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               id_valid,
   input  logic                               id_flush,
   input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_src,
   input  logic [NUM_RD_PORTS-1:0]            id_src_used,
   input  logic [REG_ADDR_W-1:0]              id_dest,
   input  logic                               id_reg_write,
   input  logic                               id_is_load,
   input  logic                               id_is_mdu,
   input  logic                               id_branch,
   output logic                               pc_enable,
   output logic                               if_id_enable,
   output logic                               id_bubble,
   output logic [2*NUM_RD_PORTS-1:0]          fwd_ex,
   output logic [NUM_RD_PORTS-1:0]            fwd_id,
   output logic                               mdu_wb_valid,
   output logic [REG_ADDR_W-1:0]              mdu_wb_dest
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                        perf_load_use_stalls,
   output logic [31:0]                        perf_mdu_stalls
`endif
);

   stage_rec_t ex_r, mem_r, wb_r, id_rec;
   logic ex_match, mem_match;
   logic hz_load, hz_br_ex, hz_br_mem, hz_mdu;
   logic mdu_raw, mdu_waw, mdu_active;
   logic stall, issue;

   function automatic logic src_match(
      input logic [REG_ADDR_W-1:0]              d,
      input logic [NUM_RD_PORTS*REG_ADDR_W-1:0] s,
      input logic [NUM_RD_PORTS-1:0]            u
   );
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_RD_PORTS; p++)
         if (u[p] && s[p*REG_ADDR_W +: REG_ADDR_W] == d)
            hit = 1'b1;
      return hit;
   endfunction

   function automatic logic fwd_hit(
      input stage_rec_t            r,
      input logic [REG_ADDR_W-1:0] s,
      input logic                  u
   );
      return u & r.valid & r.wr & (r.dest != '0) & (r.dest == s);
   endfunction

   assign ex_match  = src_match(ex_r.dest, id_src, id_src_used);
   assign mem_match = src_match(mem_r.dest, id_src, id_src_used);

   assign hz_load   = ex_r.valid & ex_r.load & ex_r.wr
                    & (ex_r.dest != '0) & ex_match;
   assign hz_br_ex  = id_branch & ex_r.valid & ex_r.wr
                    & (ex_r.dest != '0) & ex_match;
   assign hz_br_mem = id_branch & mem_r.valid & mem_r.load
                    & (mem_r.dest != '0) & mem_match;
   assign hz_mdu    = mdu_raw | mdu_waw | (id_is_mdu & mdu_active);

   assign stall = id_valid & ~id_flush
                & (hz_load | hz_br_ex | hz_br_mem | hz_mdu);
   assign issue = id_valid & ~stall & ~id_flush;

   assign pc_enable    = ~stall;
   assign if_id_enable = ~stall;
   assign id_bubble    = stall | id_flush;

   // MDU ops ride down the pipe with wr cleared so forwarding skips them
   always_comb begin
      id_rec          = '0;
      id_rec.valid    = 1'b1;
      id_rec.wr       = id_reg_write & ~id_is_mdu;
      id_rec.load     = id_is_load;
      id_rec.dest     = id_dest;
      id_rec.src      = id_src;
      id_rec.src_used = id_src_used;
   end

   // Advance the EX/MEM/WB shadow records every clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_r  <= '0;
         mem_r <= '0;
         wb_r  <= '0;
      end else begin
         wb_r  <= mem_r;
         mem_r <= ex_r;
         ex_r  <= issue ? id_rec : '0;
      end
   end

   // Operand forwarding selects, EX/MEM taking priority over MEM/WB
   always_comb begin
      fwd_ex = '0;
      fwd_id = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         if (fwd_hit(mem_r, ex_r.src[p*REG_ADDR_W +: REG_ADDR_W],
                     ex_r.src_used[p]))
            fwd_ex[2*p +: 2] = FWD_EXMEM;
         else if (fwd_hit(wb_r, ex_r.src[p*REG_ADDR_W +: REG_ADDR_W],
                          ex_r.src_used[p]))
            fwd_ex[2*p +: 2] = FWD_MEMWB;
         else
            fwd_ex[2*p +: 2] = FWD_REGFILE;
         fwd_id[p] = id_branch & ~mem_r.load
                   & fwd_hit(mem_r, id_src[p*REG_ADDR_W +: REG_ADDR_W], 1'b1);
      end
   end

   mdu_scoreboard #(
      .REG_ADDR_W   (REG_ADDR_W),
      .NUM_REGS     (NUM_REGS),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .MDU_LATENCY  (MDU_LATENCY)
   ) u_mdu (
      .clk        (clk),
      .rst        (rst),
      .issue      (issue & id_is_mdu),
      .issue_wr   (id_reg_write),
      .issue_dest (id_dest),
      .src        (id_src),
      .src_used   (id_src_used),
      .dest       (id_dest),
      .reg_write  (id_reg_write),
      .raw        (mdu_raw),
      .waw        (mdu_waw),
      .active     (mdu_active),
      .wb_valid   (mdu_wb_valid),
      .wb_dest    (mdu_wb_dest)
   );

`ifdef HAZARD_PERF_CNT_EN
   logic ld_cause;
   assign ld_cause = hz_load | hz_br_ex | hz_br_mem;

   // Saturating stall-cause counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_load_use_stalls <= '0;
         perf_mdu_stalls      <= '0;
      end else if (stall) begin
         if (ld_cause && perf_load_use_stalls != '1)
            perf_load_use_stalls <= perf_load_use_stalls + 32'd1;
         if (!ld_cause && perf_mdu_stalls != '1)
            perf_mdu_stalls <= perf_mdu_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed scenarios
// plus randomized traffic against an issue-history reference model.
module tb_hazard_scoreboard_unit;

   localparam int LAT = 4;

   logic       clk, rst;
   logic       iv, ifl, rw, ld, mdu, br;
   logic [4:0] s0, s1, dst;
   logic [1:0] used;
   logic       pc_enable, if_id_enable, id_bubble, mdu_wb_valid;
   logic [3:0] fwd_ex;
   logic [1:0] fwd_id;
   logic [4:0] mdu_wb_dest;

   int checks = 0;
   int failures = 0;

   hazard_scoreboard_unit dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (iv),
      .id_flush     (ifl),
      .id_src       ({s1, s0}),
      .id_src_used  (used),
      .id_dest      (dst),
      .id_reg_write (rw),
      .id_is_load   (ld),
      .id_is_mdu    (mdu),
      .id_branch    (br),
      .pc_enable    (pc_enable),
      .if_id_enable (if_id_enable),
      .id_bubble    (id_bubble),
      .fwd_ex       (fwd_ex),
      .fwd_id       (fwd_id),
      .mdu_wb_valid (mdu_wb_valid),
      .mdu_wb_dest  (mdu_wb_dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what was issued 1, 2 and 3 cycles ago, plus the
   // cycle on which the single outstanding MDU op writes back.
   typedef struct {
      bit valid; bit wr; bit load;
      int dest; int src0; int src1; bit u0; bit u1;
   } ins_t;

   ins_t hist[3];
   int   cyc;
   int   mdu_until;
   int   mdu_dst;
   bit   mdu_sets;

   bit         e_pc, e_bub, e_wbv;
   logic [3:0] e_fx;
   logic [1:0] e_fi;
   int         e_wbd;

   function automatic bit reads(int r);
      return (used[0] && s0 == r) || (used[1] && s1 == r);
   endfunction

   function automatic bit busy(int r);
      return cyc <= mdu_until && mdu_sets && r == mdu_dst;
   endfunction

   function automatic logic [1:0] pick(int s, bit u);
      if (u && hist[1].valid && hist[1].wr && hist[1].dest != 0 &&
          hist[1].dest == s) return 2'b10;
      if (u && hist[2].valid && hist[2].wr && hist[2].dest != 0 &&
          hist[2].dest == s) return 2'b01;
      return 2'b00;
   endfunction

   function automatic void model();
      bit st, m_ld, m_bx, m_bm, m_md;
      ins_t ex, mem;
      ex  = hist[0];
      mem = hist[1];
      m_ld = ex.valid && ex.load && ex.wr && ex.dest != 0 && reads(ex.dest);
      m_bx = br && ex.valid && ex.wr && ex.dest != 0 && reads(ex.dest);
      m_bm = br && mem.valid && mem.load && mem.dest != 0 && reads(mem.dest);
      m_md = (used[0] && busy(s0)) || (used[1] && busy(s1)) ||
             (rw && busy(dst)) || (mdu && cyc <= mdu_until);
      st = iv && !ifl && (m_ld || m_bx || m_bm || m_md);
      e_pc  = !st;
      e_bub = st || ifl;
      e_fx  = {pick(ex.src1, ex.u1), pick(ex.src0, ex.u0)};
      e_fi[0] = br && mem.valid && mem.wr && !mem.load && mem.dest != 0 &&
                mem.dest == s0;
      e_fi[1] = br && mem.valid && mem.wr && !mem.load && mem.dest != 0 &&
                mem.dest == s1;
      e_wbv = (cyc == mdu_until);
      e_wbd = mdu_dst;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) hist[i] = '{default: 0};
      mdu_until = -100;
      mdu_dst   = 0;
      mdu_sets  = 0;
      cyc       = 0;
   endtask

   // Advance one clock, updating the model with the current ID inputs
   task automatic tick();
      ins_t n;
      model();
      n = '{default: 0};
      if (iv && !ifl && e_pc) begin
         n = '{1, rw && !mdu, ld, dst, s0, s1, used[0], used[1]};
         if (mdu) begin
            mdu_until = cyc + LAT;
            mdu_dst   = dst;
            mdu_sets  = rw && dst != 0;
         end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = n;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_id(bit v, bit f, int a, int b, logic [1:0] u,
                         int d, bit w, bit l, bit m, bit bb);
      iv = v; ifl = f; s0 = 5'(a); s1 = 5'(b); used = u;
      dst = 5'(d); rw = w; ld = l; mdu = m; br = bb;
      #1;
   endtask

   task automatic idle(int n);
      set_id(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_id(1, 0, 1, 2, 2'b11, 3, 1, 0, 0, 1);
      @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({pc_enable, if_id_enable, id_bubble} !== 3'b110) begin
         failures++;
         $display("FAIL reset_ctl got=%b want=110",
                  {pc_enable, if_id_enable, id_bubble});
      end
      checks++;
      if ({fwd_ex, fwd_id} !== 6'b0) begin
         failures++;
         $display("FAIL reset_fwd got=%b want=000000", {fwd_ex, fwd_id});
      end
      checks++;
      if ({mdu_wb_valid, mdu_wb_dest} !== 6'b0) begin
         failures++;
         $display("FAIL reset_mdu got=%b want=000000",
                  {mdu_wb_valid, mdu_wb_dest});
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_load_use();
      idle(3);
      set_id(1, 0, 0, 0, 2'b00, 5, 1, 1, 0, 0);
      tick();
      set_id(1, 0, 1, 5, 2'b11, 6, 1, 0, 0, 0);
      checks++;
      if ({pc_enable, id_bubble} !== 2'b01) begin
         failures++;
         $display("FAIL load_use_stall got=%b want=01",
                  {pc_enable, id_bubble});
      end
      tick();
      checks++;
      if ({pc_enable, id_bubble} !== 2'b10) begin
         failures++;
         $display("FAIL load_use_release got=%b want=10",
                  {pc_enable, id_bubble});
      end
      tick();
      set_id(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      checks++;
      if (fwd_ex !== 4'b0100) begin
         failures++;
         $display("FAIL load_use_fwd got=%b want=0100", fwd_ex);
      end
   endtask

   task automatic test_forward();
      idle(3);
      set_id(1, 0, 1, 2, 2'b11, 3, 1, 0, 0, 0);
      tick();
      set_id(1, 0, 3, 3, 2'b11, 4, 1, 0, 0, 0);
      checks++;
      if (pc_enable !== 1'b1) begin
         failures++;
         $display("FAIL fwd_no_stall got=%b want=1", pc_enable);
      end
      tick();
      idle(0);
      checks++;
      if (fwd_ex !== 4'b1010) begin
         failures++;
         $display("FAIL fwd_exmem got=%b want=1010", fwd_ex);
      end
      idle(3);
      set_id(1, 0, 1, 2, 2'b11, 3, 1, 0, 0, 0);
      tick();
      idle(1);
      set_id(1, 0, 3, 3, 2'b11, 4, 1, 0, 0, 0);
      tick();
      idle(0);
      checks++;
      if (fwd_ex !== 4'b0101) begin
         failures++;
         $display("FAIL fwd_memwb got=%b want=0101", fwd_ex);
      end
      idle(3);
      set_id(1, 0, 1, 2, 2'b11, 0, 1, 0, 0, 0);
      tick();
      set_id(1, 0, 0, 0, 2'b11, 4, 1, 0, 0, 0);
      tick();
      idle(0);
      checks++;
      if (fwd_ex !== 4'b0000) begin
         failures++;
         $display("FAIL fwd_r0 got=%b want=0000", fwd_ex);
      end
   endtask

   task automatic test_mdu();
      idle(3);
      set_id(1, 0, 1, 2, 2'b11, 7, 1, 0, 1, 0);
      tick();
      set_id(1, 0, 7, 1, 2'b11, 9, 1, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({pc_enable, mdu_wb_valid} !== {1'b0, k == 4}) begin
            failures++;
            $display("FAIL mdu_dep_c%0d got=%b want=%b", k,
                     {pc_enable, mdu_wb_valid}, {1'b0, k == 4});
         end
         if (k == 4) begin
            checks++;
            if (mdu_wb_dest !== 5'd7) begin
               failures++;
               $display("FAIL mdu_wb_dest got=%0d want=7", mdu_wb_dest);
            end
         end
         tick();
      end
      checks++;
      if ({pc_enable, mdu_wb_valid} !== 2'b10) begin
         failures++;
         $display("FAIL mdu_dep_issue got=%b want=10",
                  {pc_enable, mdu_wb_valid});
      end
      tick();
      idle(2);
   endtask

   task automatic test_mdu_struct();
      idle(3);
      set_id(1, 0, 1, 2, 2'b00, 7, 1, 0, 1, 0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         set_id(1, k == 2, 1, 2, 2'b00, 8, 1, 0, 1, 0);
         checks++;
         if ({pc_enable, id_bubble} !== ((k == 2 || k == 5) ? 2'b11 - 2'b01 * (k == 5) : 2'b01)) begin
            failures++;
            $display("FAIL mdu_struct_c%0d got=%b", k,
                     {pc_enable, id_bubble});
         end
         tick();
      end
      idle(6);
   endtask

   task automatic test_branch();
      idle(3);
      set_id(1, 0, 1, 1, 2'b11, 2, 1, 0, 0, 0);
      tick();
      set_id(1, 0, 2, 4, 2'b11, 0, 0, 0, 0, 1);
      checks++;
      if (pc_enable !== 1'b0) begin
         failures++;
         $display("FAIL br_ex_stall got=%b want=0", pc_enable);
      end
      tick();
      checks++;
      if ({pc_enable, fwd_id} !== 3'b101) begin
         failures++;
         $display("FAIL br_fwd_id got=%b want=101", {pc_enable, fwd_id});
      end
      tick();
      idle(3);
      set_id(1, 0, 1, 1, 2'b11, 2, 1, 1, 0, 0);
      tick();
      set_id(1, 0, 2, 4, 2'b11, 0, 0, 0, 0, 1);
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if ({pc_enable, fwd_id} !== {k == 3, 2'b00}) begin
            failures++;
            $display("FAIL br_load_c%0d got=%b want=%b", k,
                     {pc_enable, fwd_id}, {k == 3, 2'b00});
         end
         tick();
      end
      idle(1);
   endtask

   task automatic test_reset_mid_mdu();
      idle(3);
      set_id(1, 0, 1, 2, 2'b00, 9, 1, 0, 1, 0);
      tick();
      idle(2);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({pc_enable, if_id_enable, id_bubble, fwd_ex, fwd_id,
           mdu_wb_valid, mdu_wb_dest} !== 15'b110_0000_00_0_00000) begin
         failures++;
         $display("FAIL reset_async got=%b", {pc_enable, if_id_enable,
                  id_bubble, fwd_ex, fwd_id, mdu_wb_valid, mdu_wb_dest});
      end
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (mdu_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_wb_c%0d got=%b want=0", k, mdu_wb_valid);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         iv  = ($urandom_range(0, 9) != 0);
         ifl = ($urandom_range(0, 11) == 0);
         s0  = 5'($urandom_range(0, 3));
         s1  = 5'($urandom_range(0, 3));
         used = 2'($urandom_range(0, 3));
         dst = 5'($urandom_range(0, 3));
         rw  = 1'($urandom_range(0, 1));
         mdu = ($urandom_range(0, 9) == 0);
         ld  = !mdu && ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 4) == 0);
         #1;
         model();
         checks++;
         if ({pc_enable, if_id_enable, id_bubble, fwd_ex, fwd_id,
              mdu_wb_valid} !== {e_pc, e_pc, e_bub, e_fx, e_fi, e_wbv}) begin
            failures++;
            $display("FAIL rand_c%0d got=%b want=%b", n,
                     {pc_enable, if_id_enable, id_bubble, fwd_ex, fwd_id,
                      mdu_wb_valid},
                     {e_pc, e_pc, e_bub, e_fx, e_fi, e_wbv});
         end
         if (e_wbv) begin
            checks++;
            if (mdu_wb_dest !== 5'(e_wbd)) begin
               failures++;
               $display("FAIL rand_wbd_c%0d got=%0d want=%0d", n,
                        mdu_wb_dest, e_wbd);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      model_reset();
      test_reset();
      test_load_use();
      test_forward();
      test_mdu();
      test_mdu_struct();
      test_branch();
      test_reset_mid_mdu();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
